// File: rtl/pc_predict_gen_pkg.sv
// Shared types for the fetch PC predictor: resolved branch types, BTB entry kinds
// and default reset/bubble addresses.
package pc_predict_gen_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JUMP = 2'd2,
        BR_CALL = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        KIND_COND = 2'd0,
        KIND_JUMP = 2'd1,
        KIND_CALL = 2'd2,
        KIND_RET  = 2'd3
    } btb_kind_e;

    localparam logic [31:0] INIT_PC_DEFAULT    = 32'hbfc00000;
    localparam logic [31:0] INVALID_PC_DEFAULT = 32'h00000000;

    // jr $ra is reported as an ordinary jump by ID; the return flag overrides its kind.
    function automatic btb_kind_e btb_kind_of(input logic [1:0] upd_type, input logic is_ret);
        btb_kind_e kind;
        kind = KIND_JUMP;
        if (is_ret) begin
            kind = KIND_RET;
        end else begin
            case (br_type_e'(upd_type))
                BR_COND: kind = KIND_COND;
                BR_CALL: kind = KIND_CALL;
                default: kind = KIND_JUMP;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/pc_predict_gen_ras_stack.sv
// Circular return address stack: pushing when full overwrites the oldest entry,
// popping when empty does nothing.
module pc_predict_gen_ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;

    // ptr is the next free slot, so the top of stack sits one below it.
    assign top   = mem[ptr - PW'(1)];
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (cnt != CW'(DEPTH)) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && cnt != '0) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_predict_gen.sv
// Fetch-stage PC generator: gshare PHT plus direct-mapped typed BTB and a return
// address stack, predicting the PC that follows the delay slot.
module pc_predict_gen
    import pc_predict_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    GHR_WIDTH   = 8,
    parameter int                    BTB_ENTRIES = 64,
    parameter int                    RAS_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] INIT_PC     = ADDR_WIDTH'(INIT_PC_DEFAULT),
    parameter logic [ADDR_WIDTH-1:0] INVALID_PC  = ADDR_WIDTH'(INVALID_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    input  logic [1:0]            upd_type,
    input  logic                  upd_is_ret,
    input  logic                  upd_taken,
    input  logic [GHR_WIDTH-1:0]  upd_pht_index,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  flush,
    input  logic                  flush_mispred,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    output logic                  pred_taken,
    output logic [GHR_WIDTH-1:0]  pred_pht_index,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - 2;
    localparam int PHT_N  = 1 << GHR_WIDTH;
    localparam int RAS_CW = $clog2(RAS_DEPTH) + 1;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [GHR_WIDTH-1:0]  ghr;
    logic [1:0]            pht [PHT_N];

    logic                  btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];
    btb_kind_e             btb_kind   [BTB_ENTRIES];

    logic [ADDR_WIDTH-1:0] ras_top;
    logic [RAS_CW-1:0]     ras_count;

    // Stage p0: combinational lookup on the current fetch PC
    logic [IDX_W-1:0]      lk_idx_p0;
    logic [TAG_W-1:0]      lk_tag_p0;
    logic                  lk_hit_p0;
    btb_kind_e             lk_kind_p0;
    logic                  lk_taken_p0;
    logic [ADDR_WIDTH-1:0] lk_target_p0;
    logic                  advance;
    logic                  ras_push;
    logic                  ras_pop;

    assign lk_idx_p0      = pc_out[IDX_W+1:2];
    assign lk_tag_p0      = pc_out[ADDR_WIDTH-1:IDX_W+2];
    assign lk_hit_p0      = btb_valid[lk_idx_p0] && (btb_tag[lk_idx_p0] == lk_tag_p0);
    assign lk_kind_p0     = btb_kind[lk_idx_p0];
    assign pred_pht_index = pc_out[GHR_WIDTH+1:2] ^ ghr;

    always_comb begin
        lk_taken_p0  = 1'b1;
        lk_target_p0 = btb_target[lk_idx_p0];
        case (lk_kind_p0)
            KIND_COND: lk_taken_p0 = pht[pred_pht_index][1];
            KIND_RET: begin
                if (ras_count != '0) lk_target_p0 = ras_top;
            end
            default: lk_taken_p0 = 1'b1;
        endcase
    end

    assign pred_taken = lk_hit_p0 && lk_taken_p0;

    always_comb begin
        if (flush)           next_pc = exc_pc;
        else if (stall)      next_pc = pc_reg;
        else if (pred_taken) next_pc = lk_target_p0;
        else                 next_pc = pc_reg + ADDR_WIDTH'(4);
    end

    assign advance  = !flush && !stall;
    assign ras_push = advance && pred_taken && (lk_kind_p0 == KIND_CALL);
    assign ras_pop  = advance && pred_taken && (lk_kind_p0 == KIND_RET);

    // Stage p1: fetch PC pair update
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out <= INIT_PC;
            pc_reg <= INIT_PC + ADDR_WIDTH'(4);
        end else if (flush) begin
            pc_reg <= exc_pc;
            // A mispredict keeps the delay slot in flight; an exception squashes it.
            if (!flush_mispred) pc_out <= INVALID_PC;
        end else if (!stall) begin
            pc_reg <= next_pc;
            pc_out <= pc_reg;
        end
    end

    // Stage p1: predictor training from ID
    logic [IDX_W-1:0] upd_idx;
    logic             upd_write;

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_write = upd_valid && (br_type_e'(upd_type) != BR_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else if (upd_write) begin
            btb_valid[upd_idx] <= 1'b1;
            if (br_type_e'(upd_type) == BR_COND) begin
                pht[upd_pht_index] <= sat_ctr(pht[upd_pht_index], upd_taken);
                ghr                <= {ghr[GHR_WIDTH-2:0], upd_taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_write) begin
            btb_tag[upd_idx]    <= upd_pc[ADDR_WIDTH-1:IDX_W+2];
            btb_target[upd_idx] <= upd_target;
            btb_kind[upd_idx]   <= btb_kind_of(upd_type, upd_is_ret);
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, upd_pc[1:0]};

    pc_predict_gen_ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_WIDTH)
    ) u_ras_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_out + ADDR_WIDTH'(8)),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule
